// File: rtl/VX_gpu_pkg.sv
// Shared GPU front-end types: commit arbiter FSM state and a sizing helper.
package VX_gpu_pkg;

  typedef logic [0:0] commit_arb_state_t;

  localparam commit_arb_state_t ARB  = 1'b0;
  localparam commit_arb_state_t LOCK = 1'b1;

  // Index width that never collapses to zero bits for a single-entry set.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/VX_elastic_buffer.sv
// Two-entry elastic buffer with registered output and registered-only readiness
// (output register plus one skid entry).
module VX_elastic_buffer #(
  parameter int unsigned DATAW   = 8,
  parameter int unsigned SIZE    = 2,
  parameter int unsigned OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             ready_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out
);

  if (SIZE != 2 || OUT_REG != 1) begin : g_bad_params
    $error("VX_elastic_buffer: only SIZE=2 with OUT_REG=1 is implemented");
  end

  logic             out_valid_q;
  logic             skid_valid_q;
  logic [DATAW-1:0] out_data_q;
  logic [DATAW-1:0] skid_data_q;
  logic             push;
  logic             out_free;

  // Readiness comes only from the skid flop, so ready_out never reaches ready_in.
  assign ready_in  = !skid_valid_q;
  assign push      = valid_in && !skid_valid_q;
  assign out_free  = !out_valid_q || ready_out;
  assign valid_out = out_valid_q;
  assign data_out  = out_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      out_valid_q  <= skid_valid_q || push;
      skid_valid_q <= 1'b0;
    end else if (push) begin
      skid_valid_q <= 1'b1;
    end
  end

  // Payload registers are intentionally not reset.
  always_ff @(posedge clk) begin
    if (out_free) begin
      if (skid_valid_q) begin
        out_data_q <= skid_data_q;
      end else if (push) begin
        out_data_q <= data_in;
      end
    end else if (push) begin
      skid_data_q <= data_in;
    end
  end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Commit arbiter: round-robin with aging and packet lock into a 2-entry output buffer.
// Define COMMIT_ARB_PERF_EN to add the perf_stalls / perf_starve_grants outputs.
module vx_commit_arbiter
  import VX_gpu_pkg::*;
#(
  parameter  int unsigned NUM_REQS     = 4,
  parameter  int unsigned DATAW        = 64,
  parameter  int unsigned STARVE_LIMIT = 15,
  parameter  int unsigned CTR_W        = 32,
  localparam int unsigned SELW         = clog2_min1(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  input  logic [NUM_REQS-1:0]       eop_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic                      eop_out,
  output logic [SELW-1:0]           sel_out,
  input  logic                      ready_out
`ifdef COMMIT_ARB_PERF_EN
  ,
  output logic [CTR_W-1:0]          perf_stalls,
  output logic [CTR_W-1:0]          perf_starve_grants
`endif
);

  localparam int unsigned WCW  = clog2_min1(STARVE_LIMIT + 1);
  localparam int unsigned BUFW = DATAW + 1 + SELW;

  if (NUM_REQS < 1 || CTR_W < 1) begin : g_bad_params
    $error("vx_commit_arbiter: NUM_REQS and CTR_W must be at least 1");
  end

  commit_arb_state_t    state_q, state_d;
  logic [SELW-1:0]      lock_q, lock_d;
  logic [SELW-1:0]      ptr_q, ptr_d;
  logic [WCW-1:0]       wait_q [NUM_REQS];

  logic [NUM_REQS-1:0]  starving;
  logic                 rr_any, starve_any;
  logic [SELW-1:0]      rr_idx, starve_idx;
  logic [SELW-1:0]      sel;
  logic                 grant, starve_win, fire, sel_eop;
  logic [DATAW-1:0]     sel_data;
  int unsigned          idx;

  logic                 buf_ready, buf_valid;
  logic [BUFW-1:0]      buf_din, buf_dout;

  // Aged requesters: waited STARVE_LIMIT cycles and still asking.
  always_comb begin
    starving = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      starving[i] = (STARVE_LIMIT != 0) && valid_in[i] && (wait_q[i] == WCW'(STARVE_LIMIT));
    end
  end

  // First valid and first starving index, scanning upward from the pointer.
  always_comb begin
    rr_any     = 1'b0;
    rr_idx     = '0;
    starve_any = 1'b0;
    starve_idx = '0;
    idx        = 0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (32'(ptr_q) + 32'(k)) % NUM_REQS;
      if (valid_in[SELW'(idx)] && !rr_any) begin
        rr_any = 1'b1;
        rr_idx = SELW'(idx);
      end
      if (starving[SELW'(idx)] && !starve_any) begin
        starve_any = 1'b1;
        starve_idx = SELW'(idx);
      end
    end
  end

  // Grant selection: lock beats aging, aging beats round-robin.
  always_comb begin
    sel        = rr_idx;
    grant      = rr_any;
    starve_win = 1'b0;
    if (state_q == LOCK) begin
      sel   = lock_q;
      grant = 1'b1;
    end else if (starve_any) begin
      sel        = starve_idx;
      grant      = 1'b1;
      starve_win = 1'b1;
    end
  end

  always_comb begin
    ready_in = '0;
    if (grant && buf_ready && !reset) begin
      ready_in[sel] = 1'b1;
    end
  end

  assign fire = |(valid_in & ready_in);

  always_comb begin
    sel_data = '0;
    sel_eop  = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (SELW'(i) == sel) begin
        sel_data = data_in[i*DATAW +: DATAW];
        sel_eop  = eop_in[i];
      end
    end
  end

  // ARB/LOCK next state, lock owner and round-robin pointer.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (fire) begin
      if (sel_eop) begin
        state_d = ARB;
        ptr_d   = (sel == SELW'(NUM_REQS - 1)) ? '0 : sel + 1'b1;
      end else begin
        state_d = LOCK;
        lock_d  = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!valid_in[i] || ready_in[i]) begin
          wait_q[i] <= '0;
        end else if (wait_q[i] != WCW'(STARVE_LIMIT)) begin
          wait_q[i] <= wait_q[i] + 1'b1;
        end
      end
    end
  end

  assign buf_din = {sel, sel_eop, sel_data};

  VX_elastic_buffer #(
    .DATAW   (BUFW),
    .SIZE    (2),
    .OUT_REG (1)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (fire),
    .data_in   (buf_din),
    .ready_in  (buf_ready),
    .valid_out (buf_valid),
    .data_out  (buf_dout),
    .ready_out (ready_out)
  );

  // Control fields are qualified by valid so they read zero out of reset.
  assign valid_out = buf_valid;
  assign data_out  = buf_dout[DATAW-1:0];
  assign eop_out   = buf_valid && buf_dout[DATAW];
  assign sel_out   = buf_valid ? buf_dout[BUFW-1 -: SELW] : '0;

`ifdef COMMIT_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stalls        <= '0;
      perf_starve_grants <= '0;
    end else begin
      if (|valid_in && !fire) begin
        perf_stalls <= perf_stalls + CTR_W'(1);
      end
      if (fire && starve_win) begin
        perf_starve_grants <= perf_starve_grants + CTR_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Directed bench for vx_commit_arbiter (NUM_REQS=4, STARVE_LIMIT=2); perf checks only
// when COMMIT_ARB_PERF_EN is defined.
module tb_vx_commit_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned SL = 2;
  localparam int unsigned CW = 32;
  localparam int unsigned SW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     valid_in;
  logic [NR*DW-1:0]  data_in;
  logic [NR-1:0]     eop_in;
  logic [NR-1:0]     ready_in;
  logic              valid_out;
  logic [DW-1:0]     data_out;
  logic              eop_out;
  logic [SW-1:0]     sel_out;
  logic              ready_out;
`ifdef COMMIT_ARB_PERF_EN
  logic [CW-1:0]     perf_stalls;
  logic [CW-1:0]     perf_starve_grants;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int cap_sel[$];
  int cap_data[$];
  int cap_eop[$];
  int cap_cyc[$];

  vx_commit_arbiter #(
    .NUM_REQS     (NR),
    .DATAW        (DW),
    .STARVE_LIMIT (SL),
    .CTR_W        (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .eop_in    (eop_in),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .eop_out   (eop_out),
    .sel_out   (sel_out),
    .ready_out (ready_out)
`ifdef COMMIT_ARB_PERF_EN
    ,
    .perf_stalls        (perf_stalls),
    .perf_starve_grants (perf_starve_grants)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output beat log, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset && valid_out && ready_out) begin
      cap_sel.push_back(int'(sel_out));
      cap_data.push_back(int'(data_out));
      cap_eop.push_back(int'(eop_out));
      cap_cyc.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int r, input int val);
    data_in[r*DW +: DW] = DW'(val);
  endtask

  task automatic clear_cap();
    cap_sel.delete();
    cap_data.delete();
    cap_eop.delete();
    cap_cyc.delete();
  endtask

  task automatic apply_reset();
    step();
    valid_in = '0;
    eop_in   = '0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    step();
    clear_cap();
  endtask

  task automatic test_reset();
    valid_in  = '1;
    eop_in    = '1;
    data_in   = '0;
    ready_out = 1'b1;
    #12;
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid_out: got %b, expected 0", valid_out); end
    tests_run++;
    if (eop_out !== 1'b0) begin tests_failed++; $display("FAIL reset_eop_out: got %b, expected 0", eop_out); end
    tests_run++;
    if (sel_out !== 2'd0) begin tests_failed++; $display("FAIL reset_sel_out: got %0d, expected 0", sel_out); end
    tests_run++;
    if (ready_in !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready_in: got %b, expected 0000", ready_in); end
`ifdef COMMIT_ARB_PERF_EN
    tests_run++;
    if (perf_stalls !== 32'd0 || perf_starve_grants !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_perf: got stalls=%0d starve=%0d, expected 0 0", perf_stalls, perf_starve_grants);
    end
`endif
    valid_in = '0;
    eop_in   = '0;
    @(posedge clk);
    #1 reset = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int exp_sel  [5] = '{0, 1, 2, 3, 0};
    int exp_data [5] = '{'hA0, 'hA1, 'hA2, 'hA3, 'hA0};
    clear_cap();
    for (int r = 0; r < NR; r++) set_data(r, 'hA0 + r);
    valid_in  = 4'hF;
    eop_in    = 4'hF;
    ready_out = 1'b1;
    #1;
    tests_run++;
    if (ready_in !== 4'b0001) begin tests_failed++; $display("FAIL rr_first_ready: got %b, expected 0001", ready_in); end
    tests_run++;
    if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL rr_idle_valid: got %b, expected 0", valid_out); end
    step();
    tests_run++;
    if (valid_out !== 1'b1 || sel_out !== 2'd0) begin
      tests_failed++;
      $display("FAIL rr_latency: got valid=%b sel=%0d, expected valid=1 sel=0", valid_out, sel_out);
    end
    repeat (4) step();
    valid_in = '0;
    repeat (3) step();
    tests_run++;
    if (cap_sel.size() != 5) begin
      tests_failed++;
      $display("FAIL rr_beat_count: got %0d, expected 5", cap_sel.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (cap_sel[i] !== exp_sel[i] || cap_data[i] !== exp_data[i] || cap_eop[i] !== 1) begin
          tests_failed++;
          $display("FAIL rr_beat%0d: got sel=%0d data=%0h eop=%0d, expected sel=%0d data=%0h eop=1",
                   i, cap_sel[i], cap_data[i], cap_eop[i], exp_sel[i], exp_data[i]);
        end
        tests_run++;
        if (cap_cyc[i] - cap_cyc[0] !== i) begin
          tests_failed++;
          $display("FAIL rr_rate%0d: got offset %0d, expected %0d", i, cap_cyc[i] - cap_cyc[0], i);
        end
      end
    end
  endtask

  task automatic test_lock();
    int exp_sel  [4] = '{1, 1, 1, 2};
    int exp_data [4] = '{'hB0, 'hB1, 'hB2, 'hC2};
    int exp_eop  [4] = '{0, 0, 1, 1};
    clear_cap();
    set_data(0, 'hC0);
    set_data(1, 'hB0);
    set_data(2, 'hC2);
    valid_in = 4'b0111;
    eop_in   = 4'b0101;
    #1;
    tests_run++;
    if (ready_in !== 4'b0010) begin tests_failed++; $display("FAIL lock_start_ready: got %b, expected 0010", ready_in); end
    step();
    set_data(1, 'hB1);
    #1;
    tests_run++;
    if (ready_in !== 4'b0010) begin tests_failed++; $display("FAIL lock_hold1_ready: got %b, expected 0010", ready_in); end
    step();
    set_data(1, 'hB2);
    eop_in = 4'b0111;
    #1;
    tests_run++;
    if (ready_in !== 4'b0010) begin tests_failed++; $display("FAIL lock_hold2_ready: got %b, expected 0010", ready_in); end
    step();
    tests_run++;
    if (ready_in !== 4'b0100) begin tests_failed++; $display("FAIL lock_next_ready: got %b, expected 0100", ready_in); end
    step();
    valid_in = '0;
    eop_in   = '0;
    repeat (3) step();
    tests_run++;
    if (cap_sel.size() != 4) begin
      tests_failed++;
      $display("FAIL lock_beat_count: got %0d, expected 4", cap_sel.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (cap_sel[i] !== exp_sel[i] || cap_data[i] !== exp_data[i] || cap_eop[i] !== exp_eop[i] ||
            cap_cyc[i] - cap_cyc[0] !== i) begin
          tests_failed++;
          $display("FAIL lock_beat%0d: got sel=%0d data=%0h eop=%0d off=%0d, expected sel=%0d data=%0h eop=%0d off=%0d",
                   i, cap_sel[i], cap_data[i], cap_eop[i], cap_cyc[i] - cap_cyc[0],
                   exp_sel[i], exp_data[i], exp_eop[i], i);
        end
      end
    end
  endtask

  task automatic test_starvation();
    apply_reset();
    set_data(3, 'hF3);
    valid_in = 4'b1001;
    eop_in   = 4'b1000;
    for (int b = 0; b < 6; b++) begin
      set_data(0, 'hE0 + b);
      eop_in[0] = (b == 5);
      #1;
      tests_run++;
      if (ready_in !== 4'b0001) begin
        tests_failed++;
        $display("FAIL starve_lock_ready%0d: got %b, expected 0001", b, ready_in);
      end
      step();
    end
    set_data(1, 'h61);
    valid_in = 4'b1010;
    eop_in   = 4'b1010;
    #1;
    tests_run++;
    if (ready_in !== 4'b1000) begin tests_failed++; $display("FAIL starve_grant_ready: got %b, expected 1000", ready_in); end
    step();
    valid_in = '0;
    eop_in   = '0;
    repeat (3) step();
    tests_run++;
    if (cap_sel.size() != 7) begin
      tests_failed++;
      $display("FAIL starve_beat_count: got %0d, expected 7", cap_sel.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        int es = (i < 6) ? 0 : 3;
        int ed = (i < 6) ? ('hE0 + i) : 'hF3;
        int ee = (i >= 5) ? 1 : 0;
        tests_run++;
        if (cap_sel[i] !== es || cap_data[i] !== ed || cap_eop[i] !== ee) begin
          tests_failed++;
          $display("FAIL starve_beat%0d: got sel=%0d data=%0h eop=%0d, expected sel=%0d data=%0h eop=%0d",
                   i, cap_sel[i], cap_data[i], cap_eop[i], es, ed, ee);
        end
      end
    end
`ifdef COMMIT_ARB_PERF_EN
    tests_run++;
    if (perf_starve_grants !== 32'd1) begin
      tests_failed++;
      $display("FAIL starve_perf_grants: got %0d, expected 1", perf_starve_grants);
    end
`endif
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic r;
    clear_cap();
    ready_out = 1'b0;
    valid_in  = 4'b0001;
    eop_in    = 4'b0001;
    for (int c = 0; c < 5; c++) begin
      set_data(0, 'hD000 + acc);
      #1 r = ready_in[0];
      step();
      if (r) acc++;
    end
    #1;
    tests_run++;
    if (acc !== 2) begin tests_failed++; $display("FAIL bp_accepted: got %0d, expected 2", acc); end
    tests_run++;
    if (ready_in !== 4'b0000) begin tests_failed++; $display("FAIL bp_full_ready: got %b, expected 0000", ready_in); end
    tests_run++;
    if (valid_out !== 1'b1 || data_out !== 16'hD000) begin
      tests_failed++;
      $display("FAIL bp_hold: got valid=%b data=%0h, expected valid=1 data=d000", valid_out, data_out);
    end
    ready_out = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_data(0, 'hD000 + acc);
      #1 r = ready_in[0];
      step();
      if (r) acc++;
    end
    valid_in = '0;
    eop_in   = '0;
    repeat (3) step();
    tests_run++;
    if (acc !== 4) begin tests_failed++; $display("FAIL bp_total_accepted: got %0d, expected 4", acc); end
    tests_run++;
    if (cap_sel.size() != 4) begin
      tests_failed++;
      $display("FAIL bp_drain_count: got %0d, expected 4", cap_sel.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (cap_sel[i] !== 0 || cap_data[i] !== ('hD000 + i) || cap_eop[i] !== 1) begin
          tests_failed++;
          $display("FAIL bp_drain%0d: got sel=%0d data=%0h, expected sel=0 data=%0h",
                   i, cap_sel[i], cap_data[i], 'hD000 + i);
        end
      end
    end
  endtask

  task automatic test_mid_lock_reset();
    clear_cap();
    ready_out = 1'b1;
    set_data(1, 'h1111);
    valid_in = 4'b0010;
    eop_in   = 4'b0000;
    #1;
    tests_run++;
    if (ready_in !== 4'b0010) begin tests_failed++; $display("FAIL mlr_first_ready: got %b, expected 0010", ready_in); end
    step();
    tests_run++;
    if (valid_out !== 1'b1 || sel_out !== 2'd1) begin
      tests_failed++;
      $display("FAIL mlr_first_beat: got valid=%b sel=%0d, expected valid=1 sel=1", valid_out, sel_out);
    end
    valid_in = 4'b0001;
    eop_in   = 4'b0001;
    #1;
    tests_run++;
    if (ready_in !== 4'b0010) begin tests_failed++; $display("FAIL mlr_lock_hold: got %b, expected 0010", ready_in); end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (valid_out !== 1'b0 || sel_out !== 2'd0 || eop_out !== 1'b0 || ready_in !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mlr_async_clear: got valid=%b sel=%0d eop=%b ready=%b, expected 0 0 0 0000",
               valid_out, sel_out, eop_out, ready_in);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    set_data(2, 'h2222);
    valid_in = 4'b0100;
    eop_in   = 4'b0100;
    #1;
    tests_run++;
    if (ready_in !== 4'b0100) begin tests_failed++; $display("FAIL mlr_fresh_ready: got %b, expected 0100", ready_in); end
    step();
    tests_run++;
    if (valid_out !== 1'b1 || sel_out !== 2'd2 || data_out !== 16'h2222 || eop_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL mlr_fresh_beat: got valid=%b sel=%0d data=%0h eop=%b, expected 1 2 2222 1",
               valid_out, sel_out, data_out, eop_out);
    end
    valid_in = '0;
    eop_in   = '0;
    repeat (2) step();
  endtask

  task automatic test_perf_stalls();
    apply_reset();
    ready_out = 1'b0;
    set_data(0, 'h5A5A);
    valid_in = 4'b0001;
    eop_in   = 4'b0001;
    repeat (5) step();
    tests_run++;
    if (ready_in !== 4'b0000) begin tests_failed++; $display("FAIL perf_full_ready: got %b, expected 0000", ready_in); end
    valid_in = '0;
    eop_in   = '0;
`ifdef COMMIT_ARB_PERF_EN
    tests_run++;
    if (perf_stalls !== 32'd3) begin tests_failed++; $display("FAIL perf_stalls: got %0d, expected 3", perf_stalls); end
    tests_run++;
    if (perf_starve_grants !== 32'd0) begin
      tests_failed++;
      $display("FAIL perf_no_starve: got %0d, expected 0", perf_starve_grants);
    end
`endif
    ready_out = 1'b1;
    repeat (3) step();
    tests_run++;
    if (cap_sel.size() != 2) begin
      tests_failed++;
      $display("FAIL perf_drain_count: got %0d, expected 2", cap_sel.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    valid_in  = '0;
    eop_in    = '0;
    data_in   = '0;
    ready_out = 1'b0;
    test_reset();
    test_round_robin();
    test_lock();
    test_starvation();
    test_backpressure();
    test_mid_lock_reset();
    test_perf_stalls();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vx_commit_arbiter.md
VX_COMMIT_ARBITER -- requirements
Module: VX_commit_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of execute-unit commit requesters (>=1).
REQ-002 SHALL have parameter DATAW, default 64, payload width per requester.
REQ-003 SHALL have parameter STARVE_LIMIT, default 15, wait cycles before a requester is starving; 0 disables aging.
REQ-004 SHALL have parameter CTR_W, default 32, perf counter width.
REQ-005 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port valid_in  in  NUM_REQS  per-requester commit valid.
REQ-008 SHALL have port data_in  in  NUM_REQS*DATAW  per-requester payload.
REQ-009 SHALL have port eop_in  in  NUM_REQS  last beat of a multi-beat commit packet.
REQ-010 SHALL have port ready_in  out  NUM_REQS  per-requester accept.
REQ-011 SHALL have port valid_out  out  1; data_out  out  DATAW; eop_out  out  1; sel_out  out  max(1,CLOG2(NUM_REQS)), the winning index.
REQ-012 SHALL have port ready_out  in  1  downstream accept.

Function
REQ-013 SHALL assert at most one ready_in bit per cycle, only for the selected requester, and only when the output buffer is not full.
REQ-014 SHALL define input fire as valid_in[g] && ready_in[g] and output fire as valid_out && ready_out.
REQ-015 SHALL have no combinational path from ready_out to any ready_in; readiness SHALL derive from registered buffer occupancy.
REQ-016 SHALL present a fired beat on valid_out exactly 1 cycle after input fire when the buffer was empty; order SHALL be preserved.
REQ-017 SHALL sustain one beat/cycle while ready_out=1, using a 2-entry buffer; a simultaneous push and pop on a full buffer SHALL not lose data.
REQ-018 SHALL implement FSM ARB/LOCK: in ARB, fire with eop_in=0 -> LOCK on that index; in LOCK only the locked index is selectable; fire with eop_in=1 -> ARB.
REQ-019 SHALL not select another requester in LOCK even if the locked requester drops valid_in.
REQ-020 SHALL keep a round-robin pointer: on an eop fire of index g it becomes (g+1) mod NUM_REQS; ARB search starts at the pointer.
REQ-021 SHALL keep a per-requester wait counter: +1 on cycles with valid_in high and no fire, saturating at STARVE_LIMIT; cleared on fire or when valid_in is low.
REQ-022 SHALL, in ARB, give starving requesters (counter==STARVE_LIMIT) priority over round-robin, with the first starving index found from the pointer winning.
REQ-023 SHALL not let starvation preempt LOCK.
REQ-024 SHALL treat NUM_REQS=1 as a pass-through through the buffer with sel_out=0.

Reset
REQ-025 SHALL, on reset assertion, asynchronously set FSM=ARB, pointer=0, wait counters=0, buffer empty, valid_out=0, eop_out=0, sel_out=0, ready_in=0, and perf counters=0.
REQ-026 SHALL not reset the payload registers; data_out is don't-care while valid_out=0.
REQ-027 SHALL discard an in-flight locked packet on mid-packet reset; after release, the first fire SHALL be arbitrated afresh.

Configuration
REQ-028 SHALL, with COMMIT_ARB_PERF_EN defined, add outputs perf_stalls (CTR_W) and perf_starve_grants (CTR_W), both wrapping.
REQ-029 perf_stalls SHALL count cycles with |valid_in and no input fire.
REQ-030 perf_starve_grants SHALL count fires won through the starvation path.
REQ-031 SHALL, without COMMIT_ARB_PERF_EN, omit both ports and their logic; all other behaviour is identical.

Structure
REQ-032 SHALL place the FSM state typedef (commit_arb_state_t: ARB, LOCK) in VX_gpu_pkg.
REQ-033 SHALL implement the output buffer as one sub-module instance, VX_elastic_buffer (SIZE=2, OUT_REG=1), with width DATAW+1+sel width.

Verification
REQ-034 Bench: NUM_REQS=4; all valid, eop=1, ready_out=1 -> sel_out sequence 0,1,2,3,0; one beat/cycle after 1-cycle latency.
REQ-035 Bench: req1 sends 3 beats (eop on the third) while req0 and req2 are valid -> sel_out 1,1,1 contiguous, then 2; pointer=2.
REQ-036 Bench: STARVE_LIMIT=2; req0 locks for 6 beats while req3 waits, then LOCK ends with req1 and req3 valid and the pointer at 1 -> req3 is granted next; perf_starve_grants=1.
REQ-037 Bench: ready_out=0 for 5 cycles with req0 streaming -> exactly 2 beats accepted and ready_in=0 afterwards; on release, beats drain in order with no loss or duplicate.
REQ-038 Bench: reset asserted mid-LOCK for 1 cycle, asynchronously between edges -> outputs clear immediately; after release, req2 alone valid is granted.
REQ-039 Bench: PERF_EN build with 3 stalled cycles -> perf_stalls=3; non-PERF build compiles without the perf ports.
